hart_ar_arbiter: RTL and testbench
==================================

HART_AR_ARBITER -- requirements
Module: hart_ar_arbiter

Interface
REQ-001 SHALL have parameter NrHarts, default 2, giving the number of requesting harts (>=2).
REQ-002 SHALL have parameter AddrWidth, default 64, giving the read address width.
REQ-003 SHALL have parameter DataWidth, default 64, giving the read data width.
REQ-004 SHALL have parameter IdWidth, default 4, giving the per-hart transaction ID width.
REQ-005 SHALL have parameter MaxOutstanding, default 4, giving the maximum in-flight bursts per hart (1..15).
REQ-006 SHALL have ports: clk_i input 1 clock; rst_ni input 1 asynchronous active-low reset.
REQ-007 SHALL have ports: ar_valid_i input NrHarts, ar_ready_o output NrHarts, ar_addr_i input NrHarts x AddrWidth, ar_id_i input NrHarts x IdWidth (hart read requests).
REQ-008 SHALL have ports: ar_valid_o output 1, ar_ready_i input 1, ar_addr_o output AddrWidth, ar_id_o output IdWidth+IdxW (shared downstream request); IdxW = ceil(log2(NrHarts)).
REQ-009 SHALL have ports: r_valid_i input 1, r_ready_o output 1, r_id_i input IdWidth+IdxW, r_data_i input DataWidth, r_last_i input 1 (shared response).
REQ-010 SHALL have ports: r_valid_o output NrHarts, r_ready_i input NrHarts, r_id_o output IdWidth, r_data_o output DataWidth, r_last_o output 1 (response broadcast to harts).
REQ-011 SHALL have port stall_cnt_o output NrHarts x 32, giving per-hart cycles spent valid but not granted.

Function
REQ-012 SHALL use FSM IDLE/LOCKED: IDLE selects an eligible hart and drives ar_valid_o; if ar_ready_i=0 the FSM enters LOCKED, holding the hart, address and ID stable until ar_ready_i=1.
REQ-013 SHALL treat a hart as eligible when ar_valid_i is set and its outstanding count is below MaxOutstanding.
REQ-014 SHALL select round-robin, starting at the hart after the last granted one; the pointer advances only on ar_valid_o & ar_ready_i.
REQ-015 SHALL have zero-cycle request latency: a grant in IDLE drives ar_valid_o in the same cycle, and ar_ready_o[g] = ar_ready_i for granted hart g only.
REQ-016 SHALL form ar_id_o as {hart index, ar_id_i[g]}.
REQ-017 SHALL keep one outstanding counter per hart: +1 on AR handshake, -1 on an R handshake with r_last_i for that hart, unchanged on both together; the counter never exceeds MaxOutstanding or underflows.
REQ-018 SHALL route responses by r_id_i upper IdxW bits: r_valid_o[h] = r_valid_i for the addressed hart, r_ready_o = r_ready_i[h], r_id_o = r_id_i lower IdWidth bits; data and last are broadcast.
REQ-019 SHALL drive r_valid_o all-zero and r_ready_o=1 (response dropped) when the index is >= NrHarts.
REQ-020 SHALL combinationally update AR and R paths in the same cycle with no interaction other than counter arithmetic.
REQ-021 SHALL increment stall_cnt_o[h] each cycle hart h has ar_valid_i=1 and is not handshaken, saturating at 2^32-1.

Reset
REQ-022 SHALL on rst_ni=0, asynchronously: FSM=IDLE, RR pointer=0, counters=0, stall counts=0, ar_valid_o=0, ar_ready_o=0, r_valid_o=0.
REQ-023 SHALL on reset mid-burst drop the lock and all in-flight accounting; responses arriving after reset route per REQ-018 with counter decrements clamped at 0.

Configuration
REQ-024 SHALL with HART_ARB_STALL_CNT_EN defined implement REQ-021; without it, stall_cnt_o is tied to 0 and no counter flops exist.

Structure
REQ-025 SHALL place the FSM state enum and the index-width helper constant in shared package hart_arb_pkg.
REQ-026 SHALL implement selection in one sub-module rr_select (eligibility vector + pointer -> one-hot grant, valid).

Verification
REQ-027 SHALL test both harts valid in IDLE with ptr=0 and ar_ready_i=1 for 4 cycles -> grants 1,0,1,0 and ar_id_o MSB alternates.
REQ-028 SHALL test hart 0 valid with addr 0x8000_0000 and ar_ready_i=0 for 3 cycles while hart 1 raises valid -> ar_addr_o stays 0x8000_0000 and hart 1 is not granted until the handshake.
REQ-029 SHALL test hart 1 issuing 4 bursts with no R -> 5th request blocked (ar_ready_o[1]=0) while hart 0 is still granted; one R last for hart 1 -> hart 1 granted next cycle.
REQ-030 SHALL test r_id_i=5'b1_0011 with r_last_i=1 -> r_valid_o=2'b10, r_id_o=4'h3, hart 1 counter decrements; a simultaneous AR handshake leaves the counter unchanged.
REQ-031 SHALL test rst_ni pulsed low while LOCKED -> ar_valid_o=0 immediately and all counters read 0.
REQ-032 SHALL test, with HART_ARB_STALL_CNT_EN, hart 0 held valid and blocked for 10 cycles -> stall_cnt_o[0]=10; without the macro it reads 0.

Source files
------------

// File: rtl/hart_arb_pkg.sv
// Shared types and helpers for the hart read-address arbiter.
package hart_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Outstanding counters hold up to 15 in-flight bursts.
    localparam int CntWidth = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hart_ar_arbiter_rr_select.sv
// Round-robin picker: first eligible hart strictly after ptr, wrapping around.
module rr_select
    import hart_arb_pkg::*;
#(
    parameter int NrHarts = 2,
    parameter int IdxW    = idx_width(NrHarts)
) (
    input  logic [NrHarts-1:0] eligible,
    input  logic [IdxW-1:0]    ptr,
    output logic [NrHarts-1:0] grant,
    output logic [IdxW-1:0]    grant_idx,
    output logic               valid
);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = 0;
        for (int off = 1; off <= NrHarts; off++) begin
            cand = (int'(ptr) + off) % NrHarts;
            if (!valid && eligible[cand]) begin
                valid       = 1'b1;
                grant_idx   = IdxW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hart_ar_arbiter.sv
// Multi-hart AR arbiter with ID-based R routing and per-hart outstanding limits.
// Optional per-hart stall counters are built when HART_ARB_STALL_CNT_EN is defined.
module hart_ar_arbiter
    import hart_arb_pkg::*;
#(
    parameter  int NrHarts        = 2,
    parameter  int AddrWidth      = 64,
    parameter  int DataWidth      = 64,
    parameter  int IdWidth        = 4,
    parameter  int MaxOutstanding = 4,
    localparam int IdxW           = idx_width(NrHarts)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NrHarts-1:0]                 ar_valid_i,
    output logic [NrHarts-1:0]                 ar_ready_o,
    input  logic [NrHarts-1:0][AddrWidth-1:0]  ar_addr_i,
    input  logic [NrHarts-1:0][IdWidth-1:0]    ar_id_i,
    output logic                               ar_valid_o,
    input  logic                               ar_ready_i,
    output logic [AddrWidth-1:0]               ar_addr_o,
    output logic [IdWidth+IdxW-1:0]            ar_id_o,
    input  logic                               r_valid_i,
    output logic                               r_ready_o,
    input  logic [IdWidth+IdxW-1:0]            r_id_i,
    input  logic [DataWidth-1:0]               r_data_i,
    input  logic                               r_last_i,
    output logic [NrHarts-1:0]                 r_valid_o,
    input  logic [NrHarts-1:0]                 r_ready_i,
    output logic [IdWidth-1:0]                 r_id_o,
    output logic [DataWidth-1:0]               r_data_o,
    output logic                               r_last_o,
    output logic [NrHarts-1:0][31:0]           stall_cnt_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    arb_state_e           state_reg, state_next;
    logic [IdxW-1:0]      ptr_reg;
    logic [IdxW-1:0]      lock_idx_reg;
    logic [AddrWidth-1:0] lock_addr_reg;
    logic [IdWidth-1:0]   lock_id_reg;
    logic [CntWidth-1:0]  cnt_reg [NrHarts];

    logic [NrHarts-1:0]   eligible;
    logic [NrHarts-1:0]   sel_grant;
    logic [IdxW-1:0]      sel_idx;
    logic                 sel_valid;
    logic [IdxW-1:0]      gnt_idx;
    logic                 ar_hs;
    logic [IdxW-1:0]      r_idx;
    logic                 r_in_range;
    logic                 r_last_hs;

    rr_select #(
        .NrHarts (NrHarts),
        .IdxW    (IdxW)
    ) u_rr_select (
        .eligible  (eligible),
        .ptr       (ptr_reg),
        .grant     (sel_grant),
        .grant_idx (sel_idx),
        .valid     (sel_valid)
    );

    // Outputs are gated by rst_ni so that asserting reset silences the bus at once.
    always_comb begin
        state_next = state_reg;
        gnt_idx    = sel_idx;
        ar_addr_o  = ar_addr_i[sel_idx];
        ar_id_o    = {sel_idx, ar_id_i[sel_idx]};
        ar_valid_o = sel_valid && rst_ni;
        ar_ready_o = sel_grant & {NrHarts{ar_ready_i && rst_ni}};
        if (state_reg == ST_LOCKED) begin
            gnt_idx    = lock_idx_reg;
            ar_addr_o  = lock_addr_reg;
            ar_id_o    = {lock_idx_reg, lock_id_reg};
            ar_valid_o = rst_ni;
            ar_ready_o = '0;
            ar_ready_o[lock_idx_reg] = ar_ready_i && rst_ni;
        end
        ar_hs = ar_valid_o && ar_ready_i;
        case (state_reg)
            ST_IDLE:   if (sel_valid && !ar_ready_i) state_next = ST_LOCKED;
            ST_LOCKED: if (ar_ready_i) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            lock_idx_reg  <= '0;
            lock_addr_reg <= '0;
            lock_id_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (ar_hs) ptr_reg <= gnt_idx;
            if (state_reg == ST_IDLE && sel_valid) begin
                lock_idx_reg  <= sel_idx;
                lock_addr_reg <= ar_addr_i[sel_idx];
                lock_id_reg   <= ar_id_i[sel_idx];
            end
        end
    end

    assign r_idx = r_id_i[IdWidth +: IdxW];

    // Only non-power-of-two hart counts can see an index with no hart behind it.
    if ((2 ** IdxW) > NrHarts) begin : g_range_chk
        assign r_in_range = (int'(r_idx) < NrHarts);
    end else begin : g_range_all
        assign r_in_range = 1'b1;
    end

    always_comb begin
        r_valid_o = '0;
        r_ready_o = 1'b1;
        if (r_in_range) begin
            r_ready_o        = r_ready_i[r_idx];
            r_valid_o[r_idx] = r_valid_i && rst_ni;
        end
    end

    assign r_last_hs = r_valid_i && r_ready_o && r_last_i && r_in_range;
    assign r_id_o    = r_id_i[IdWidth-1:0];
    assign r_data_o  = r_data_i;
    assign r_last_o  = r_last_i;

    for (genvar gi = 0; gi < NrHarts; gi++) begin : g_hart
        logic inc, dec;
        assign eligible[gi] = ar_valid_i[gi] && (cnt_reg[gi] < MaxCnt);
        assign inc = ar_hs && (gnt_idx == IdxW'(gi)) && (cnt_reg[gi] != MaxCnt);
        // A stray last beat (e.g. after reset) must not wrap the counter.
        assign dec = r_last_hs && (r_idx == IdxW'(gi)) && (cnt_reg[gi] != '0);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_reg[gi] <= '0;
            end else if (inc && !dec) begin
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end else if (dec && !inc) begin
                cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
            end
        end

`ifdef HART_ARB_STALL_CNT_EN
        logic [31:0] stall_reg;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stall_reg <= '0;
            end else if (ar_valid_i[gi] && !ar_ready_o[gi] && (stall_reg != '1)) begin
                stall_reg <= stall_reg + 32'd1;
            end
        end
        assign stall_cnt_o[gi] = stall_reg;
`else
        assign stall_cnt_o[gi] = '0;
`endif
    end

endmodule

// File: tb/tb_hart_ar_arbiter.sv
// Scenario bench for hart_ar_arbiter (2 harts, 4-bit IDs, 4 outstanding per hart).
module tb_hart_ar_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [N-1:0]         ar_valid_i;
    logic [N-1:0]         ar_ready_o;
    logic [N-1:0][AW-1:0] ar_addr_i;
    logic [N-1:0][IW-1:0] ar_id_i;
    logic                 ar_valid_o;
    logic                 ar_ready_i;
    logic [AW-1:0]        ar_addr_o;
    logic [IW:0]          ar_id_o;
    logic                 r_valid_i;
    logic                 r_ready_o;
    logic [IW:0]          r_id_i;
    logic [DW-1:0]        r_data_i;
    logic                 r_last_i;
    logic [N-1:0]         r_valid_o;
    logic [N-1:0]         r_ready_i;
    logic [IW-1:0]        r_id_o;
    logic [DW-1:0]        r_data_o;
    logic                 r_last_o;
    logic [N-1:0][31:0]   stall_cnt_o;

    typedef struct {
        int          hart;
        logic [63:0] addr;
        logic [4:0]  id;
    } ar_exp_t;

    ar_exp_t exp_q[$];
    ar_exp_t e;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    hart_ar_arbiter #(
        .NrHarts(N), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i), .ar_id_i(ar_id_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_id_i(r_id_i), .r_data_i(r_data_i),
        .r_last_i(r_last_i), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
        .r_data_o(r_data_o), .r_last_o(r_last_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Returns a hart's outstanding bursts with a last beat; no checking here.
    task automatic retire(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            r_valid_i = 1'b1;
            r_last_i  = 1'b1;
            r_ready_i = 2'b11;
            r_id_i    = {h[0], 4'h0};
            $display("R    last for hart %0d", h);
            cyc();
        end
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        ar_valid_i = '0; ar_ready_i = 1'b0; ar_addr_i = '0; ar_id_i = '0;
        r_valid_i = 1'b0; r_id_i = '0; r_data_i = '0; r_last_i = 1'b0; r_ready_i = 2'b11;
        #2;
        ar_valid_i = 2'b11;
        ar_ready_i = 1'b1;
        #1;
        n_checks++;
        if (ar_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ar_valid: got %b expected 0", ar_valid_o); end
        n_checks++;
        if (ar_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ar_ready: got %b expected 00", ar_ready_o); end
        n_checks++;
        if (r_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_r_valid: got %b expected 00", r_valid_o); end
        n_checks++;
        if (stall_cnt_o !== '0) begin n_fail++; $display("FAIL reset_stall: got %h expected 0", stall_cnt_o); end
        cyc();
        cyc();
        ar_valid_i = '0;
        ar_ready_i = 1'b0;
        rst_ni = 1'b1;
        $display("RST  released");
    endtask

    task automatic test_round_robin();
        int exp_g;
        ar_addr_i[0] = 64'h1000; ar_addr_i[1] = 64'h2000;
        ar_id_i[0] = 4'hA; ar_id_i[1] = 4'h5;
        ar_valid_i = 2'b11;
        ar_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 1 : 0;
            exp_q.push_back('{hart: exp_g, addr: (exp_g == 1) ? 64'h2000 : 64'h1000,
                              id: (exp_g == 1) ? 5'b1_0101 : 5'b0_1010});
            #1;
            n_checks++;
            if (!(ar_valid_o && ar_ready_i) || exp_q.size() == 0) begin
                n_fail++; $display("FAIL rr_hs%0d: ar_valid_o=%b expected 1", i, ar_valid_o);
            end else begin
                e = exp_q.pop_front();
                $display("AR   hart %0d addr %h id %h", e.hart, ar_addr_o, ar_id_o);
                n_checks++;
                if (ar_ready_o !== (2'b01 << e.hart)) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected hart %0d", i, ar_ready_o, e.hart); end
                n_checks++;
                if (ar_id_o !== e.id) begin n_fail++; $display("FAIL rr_id%0d: got %h expected %h", i, ar_id_o, e.id); end
                n_checks++;
                if (ar_addr_o !== e.addr) begin n_fail++; $display("FAIL rr_addr%0d: got %h expected %h", i, ar_addr_o, e.addr); end
            end
            cyc();
        end
        ar_valid_i = '0;
        ar_ready_i = 1'b0;
        n_checks++;
        if (dut.cnt_reg[0] !== 4'd2 || dut.cnt_reg[1] !== 4'd2) begin
            n_fail++; $display("FAIL rr_counts: got %0d/%0d expected 2/2", dut.cnt_reg[0], dut.cnt_reg[1]);
        end
        retire(0, 2);
        retire(1, 2);
        n_checks++;
        if (dut.cnt_reg[0] !== 4'd0 || dut.cnt_reg[1] !== 4'd0) begin
            n_fail++; $display("FAIL rr_drain: got %0d/%0d expected 0/0", dut.cnt_reg[0], dut.cnt_reg[1]);
        end
    endtask

    task automatic test_lock();
        ar_addr_i[0] = 64'h8000_0000; ar_id_i[0] = 4'h7;
        ar_addr_i[1] = 64'h9000;      ar_id_i[1] = 4'h2;
        ar_valid_i = 2'b01;
        ar_ready_i = 1'b0;
        exp_q.push_back('{hart: 0, addr: 64'h8000_0000, id: 5'b0_0111});
        #1;
        n_checks++;
        if (ar_valid_o !== 1'b1 || ar_addr_o !== 64'h8000_0000) begin
            n_fail++; $display("FAIL lock_req: valid=%b addr=%h expected 1/80000000", ar_valid_o, ar_addr_o);
        end
        cyc();
        ar_valid_i = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (ar_addr_o !== 64'h8000_0000) begin n_fail++; $display("FAIL lock_addr%0d: got %h expected 80000000", i, ar_addr_o); end
            n_checks++;
            if (ar_ready_o !== 2'b00 || ar_id_o[4] !== 1'b0) begin
                n_fail++; $display("FAIL lock_hold%0d: ready=%b idmsb=%b expected 00/0", i, ar_ready_o, ar_id_o[4]);
            end
            cyc();
        end
        ar_ready_i = 1'b1;
        #1;
        n_checks++;
        if (ar_ready_o !== 2'b01 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL lock_release: ready=%b expected 01", ar_ready_o);
        end else begin
            e = exp_q.pop_front();
            $display("AR   hart %0d addr %h id %h", e.hart, ar_addr_o, ar_id_o);
            n_checks++;
            if (ar_addr_o !== e.addr || ar_id_o !== e.id) begin
                n_fail++; $display("FAIL lock_payload: addr=%h id=%h expected %h/%h", ar_addr_o, ar_id_o, e.addr, e.id);
            end
        end
        cyc();
        ar_valid_i = 2'b10;
        exp_q.push_back('{hart: 1, addr: 64'h9000, id: 5'b1_0010});
        #1;
        e = exp_q.pop_front();
        $display("AR   hart %0d addr %h id %h", e.hart, ar_addr_o, ar_id_o);
        n_checks++;
        if (ar_ready_o !== 2'b10 || ar_addr_o !== e.addr || ar_id_o !== e.id) begin
            n_fail++; $display("FAIL lock_next: ready=%b addr=%h id=%h expected 10/%h/%h", ar_ready_o, ar_addr_o, ar_id_o, e.addr, e.id);
        end
        cyc();
        ar_valid_i = '0;
        ar_ready_i = 1'b0;
        retire(0, 1);
        retire(1, 1);
    endtask

    task automatic test_max_outstanding();
        ar_valid_i = 2'b10;
        ar_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            $display("AR   hart 1 burst %0d id %h", i, ar_id_o);
            n_checks++;
            if (ar_ready_o !== 2'b10) begin n_fail++; $display("FAIL max_fill%0d: got %b expected 10", i, ar_ready_o); end
            cyc();
        end
        ar_valid_i = 2'b11;
        #1;
        n_checks++;
        if (ar_ready_o !== 2'b01) begin n_fail++; $display("FAIL max_block: got %b expected 01", ar_ready_o); end
        cyc();
        ar_valid_i = 2'b10;
        ar_ready_i = 1'b0;
        r_valid_i = 1'b1; r_last_i = 1'b1; r_ready_i = 2'b11; r_id_i = 5'b1_0000;
        #1;
        n_checks++;
        if (ar_valid_o !== 1'b0) begin n_fail++; $display("FAIL max_still_blocked: got %b expected 0", ar_valid_o); end
        cyc();
        r_valid_i = 1'b0; r_last_i = 1'b0;
        ar_valid_i = 2'b11;
        ar_ready_i = 1'b1;
        #1;
        n_checks++;
        if (ar_ready_o !== 2'b10) begin n_fail++; $display("FAIL max_unblock: got %b expected 10", ar_ready_o); end
        cyc();
        ar_valid_i = '0;
        ar_ready_i = 1'b0;
    endtask

    task automatic test_r_route();
        r_valid_i = 1'b1; r_last_i = 1'b1; r_id_i = 5'b1_0011;
        r_data_i = {$urandom(), $urandom()};
        r_ready_i = 2'b10;
        #1;
        $display("R    id %h data %h", r_id_i, r_data_i);
        n_checks++;
        if (r_valid_o !== 2'b10 || r_id_o !== 4'h3) begin
            n_fail++; $display("FAIL r_route: valid=%b id=%h expected 10/3", r_valid_o, r_id_o);
        end
        n_checks++;
        if (r_ready_o !== 1'b1 || r_data_o !== r_data_i || r_last_o !== 1'b1) begin
            n_fail++; $display("FAIL r_bcast: ready=%b data=%h last=%b expected 1/%h/1", r_ready_o, r_data_o, r_last_o, r_data_i);
        end
        cyc();
        n_checks++;
        if (dut.cnt_reg[1] !== 4'd3) begin n_fail++; $display("FAIL r_dec: got %0d expected 3", dut.cnt_reg[1]); end
        ar_valid_i = 2'b10;
        ar_ready_i = 1'b1;
        #1;
        n_checks++;
        if (ar_ready_o !== 2'b10 || r_valid_o !== 2'b10) begin
            n_fail++; $display("FAIL r_simul_hs: ar_ready=%b r_valid=%b expected 10/10", ar_ready_o, r_valid_o);
        end
        cyc();
        n_checks++;
        if (dut.cnt_reg[1] !== 4'd3) begin n_fail++; $display("FAIL r_simul_cnt: got %0d expected 3", dut.cnt_reg[1]); end
        ar_valid_i = '0;
        ar_ready_i = 1'b0;
        r_id_i = 5'b0_1001;
        r_ready_i = 2'b10;
        #1;
        n_checks++;
        if (r_valid_o !== 2'b01 || r_ready_o !== 1'b0 || r_id_o !== 4'h9) begin
            n_fail++; $display("FAIL r_backpressure: valid=%b ready=%b id=%h expected 01/0/9", r_valid_o, r_ready_o, r_id_o);
        end
        cyc();
        n_checks++;
        if (dut.cnt_reg[0] !== 4'd1) begin n_fail++; $display("FAIL r_no_hs_cnt: got %0d expected 1", dut.cnt_reg[0]); end
        r_id_i = 5'b1_0000; r_last_i = 1'b0; r_ready_i = 2'b11;
        cyc();
        n_checks++;
        if (dut.cnt_reg[1] !== 4'd3) begin n_fail++; $display("FAIL r_not_last_cnt: got %0d expected 3", dut.cnt_reg[1]); end
        r_valid_i = 1'b0;
    endtask

    task automatic test_reset_locked();
        ar_addr_i[0] = 64'h8000_0000; ar_id_i[0] = 4'h1;
        ar_valid_i = 2'b01;
        ar_ready_i = 1'b0;
        exp_q.push_back('{hart: 0, addr: 64'h8000_0000, id: 5'b0_0001});
        cyc();
        n_checks++;
        if (ar_valid_o !== 1'b1 || ar_ready_o !== 2'b00) begin
            n_fail++; $display("FAIL rstlk_locked: valid=%b ready=%b expected 1/00", ar_valid_o, ar_ready_o);
        end
        r_valid_i = 1'b1; r_id_i = 5'b1_0000; r_ready_i = 2'b11;
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        $display("RST  asserted while locked");
        n_checks++;
        if (ar_valid_o !== 1'b0 || ar_ready_o !== 2'b00 || r_valid_o !== 2'b00) begin
            n_fail++; $display("FAIL rstlk_outputs: ar_valid=%b ar_ready=%b r_valid=%b expected 0/00/00", ar_valid_o, ar_ready_o, r_valid_o);
        end
        n_checks++;
        if (dut.cnt_reg[0] !== 4'd0 || dut.cnt_reg[1] !== 4'd0) begin
            n_fail++; $display("FAIL rstlk_counts: got %0d/%0d expected 0/0", dut.cnt_reg[0], dut.cnt_reg[1]);
        end
        r_valid_i = 1'b0;
        cyc();
        rst_ni = 1'b1;
        ar_ready_i = 1'b1;
        #1;
        n_checks++;
        if (ar_ready_o !== 2'b01 || ar_addr_o !== 64'h8000_0000) begin
            n_fail++; $display("FAIL rstlk_regrant: ready=%b addr=%h expected 01/80000000", ar_ready_o, ar_addr_o);
        end
        cyc();
        ar_valid_i = '0;
        ar_ready_i = 1'b0;
        r_valid_i = 1'b1; r_last_i = 1'b1; r_id_i = 5'b1_0000;
        cyc();
        r_valid_i = 1'b0; r_last_i = 1'b0;
        n_checks++;
        if (dut.cnt_reg[1] !== 4'd0 || dut.cnt_reg[0] !== 4'd1) begin
            n_fail++; $display("FAIL rstlk_clamp: got %0d/%0d expected 1/0", dut.cnt_reg[0], dut.cnt_reg[1]);
        end
        retire(0, 1);
    endtask

    task automatic test_stall();
        logic [31:0] exp_stall;
`ifdef HART_ARB_STALL_CNT_EN
        exp_stall = 32'd10;
`else
        exp_stall = 32'd0;
`endif
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        ar_valid_i = 2'b01;
        ar_ready_i = 1'b0;
        repeat (10) cyc();
        $display("STL  hart 0 count %0d", stall_cnt_o[0]);
        n_checks++;
        if (stall_cnt_o[0] !== exp_stall || stall_cnt_o[1] !== 32'd0) begin
            n_fail++; $display("FAIL stall_count: got %0d/%0d expected %0d/0", stall_cnt_o[0], stall_cnt_o[1], exp_stall);
        end
        ar_ready_i = 1'b1;
        cyc();
        ar_valid_i = '0;
        ar_ready_i = 1'b0;
        n_checks++;
        if (stall_cnt_o[0] !== exp_stall) begin
            n_fail++; $display("FAIL stall_hold: got %0d expected %0d", stall_cnt_o[0], exp_stall);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_max_outstanding();
        test_r_route();
        test_reset_locked();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
